// File: rtl/key_insert_pkg.sv
// Shared layout constants and types for the key_insert write-back block.
// Optional KEY_INSERT_STATS_EN adds an insert counter in the top; nothing here depends on it.
package key_insert_pkg;

  localparam int C6_W   = 48;
  localparam int C4_W   = 32;
  localparam int C2_W   = 16;
  localparam int N_CONT = 8;
  localparam int N_SLOT = 6;
  localparam int IDX_W  = 3;
  localparam int CMP_W  = 5;

  // PHV regions, LSB upwards: metadata, com_op, 2B, 4B, 6B containers
  localparam int META_W  = 256;
  localparam int COMOP_W = 5 * 20;
  localparam int C2_BASE = META_W + COMOP_W;
  localparam int C4_BASE = C2_BASE + N_CONT * C2_W;
  localparam int C6_BASE = C4_BASE + N_CONT * C4_W;

  localparam int VLAN_LSB   = 129;
  localparam int VLAN_MSB   = 140;
  localparam int TENANT_LSB = VLAN_LSB + 4;

  localparam int INS_ENTRY_W = N_SLOT * IDX_W + N_SLOT;

  // Element [N_SLOT-1] of each packed array belongs to slot0.
  typedef struct packed {
    logic [N_SLOT-1:0][IDX_W-1:0] idx;
    logic [N_SLOT-1:0]            en;
  } ins_entry_t;

  // Key-format values without the trailing cmp bits; [1] is the even slot of each pair.
  typedef struct packed {
    logic [1:0][C6_W-1:0] v6;
    logic [1:0][C4_W-1:0] v4;
    logic [1:0][C2_W-1:0] v2;
  } ins_val_t;

endpackage

// File: rtl/key_insert_ram.sv
// Per-tenant insert-offset table: inferred simple dual-port RAM, synchronous read-first.
// Contents are not reset.
module key_insert_ram
  import key_insert_pkg::*;
#(
  parameter int DATA_W = INS_ENTRY_W,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // A same-address write lands after the read samples, so the read sees the old entry.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/key_insert.sv
// Writes up to six key-format values back into PHV containers chosen by a per-tenant table.
// Define KEY_INSERT_STATS_EN to add the saturating ins_cnt_out insert counter.
module key_insert
  import key_insert_pkg::*;
#(
  parameter int STAGE              = 0,
  parameter int PHV_LEN            = 1124,
  parameter int KEY_LEN            = 197,
  parameter int INS_OFF            = 24,
  parameter int AXIL_WIDTH         = 32,
  parameter int INS_OFF_ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_valid_in,
  input  logic [KEY_LEN-1:0]            val_in,
  input  logic [AXIL_WIDTH-1:0]         ins_off_entry_in,
  input  logic                          ins_off_entry_in_valid,
  input  logic [INS_OFF_ADDR_WIDTH-1:0] ins_off_entry_addr,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic                          phv_valid_out
`ifdef KEY_INSERT_STATS_EN
  ,
  output logic [31:0]                   ins_cnt_out
`endif
);

  logic [PHV_LEN-1:0] phv_p1_q;
  ins_val_t           val_p1_q;
  logic               vld_p1_q;
  ins_entry_t         entry_p1;
  logic [PHV_LEN-1:0] phv_d;
  logic [PHV_LEN-1:0] phv_out_q;
  logic               vld_out_q;

  // Upper config bits, cmp bits and the stage index carry no behaviour here.
  logic unused_ok;
  assign unused_ok = ^{ins_off_entry_in[AXIL_WIDTH-1:INS_OFF], val_in[CMP_W-1:0], 3'(STAGE)};

  key_insert_ram #(
    .DATA_W (INS_OFF),
    .ADDR_W (INS_OFF_ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ins_off_entry_in_valid),
    .waddr_i (ins_off_entry_addr),
    .wdata_i (ins_off_entry_in[INS_OFF-1:0]),
    .raddr_i (phv_in[TENANT_LSB +: INS_OFF_ADDR_WIDTH]),
    .rdata_o (entry_p1)
  );

  // ---- stage 0 -> 1: capture PHV and values while the table is read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_p1_q <= '0;
      val_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      phv_p1_q <= phv_in;
      val_p1_q <= val_in[KEY_LEN-1:CMP_W];
      vld_p1_q <= phv_valid_in;
    end
  end

  // Within a pair the odd slot is written first so the lower-numbered slot overrides it.
  always_comb begin
    phv_d = phv_p1_q;
    for (int j = 0; j < 3; j++) begin
      for (int k = 1; k >= 0; k--) begin
        if (entry_p1.en[N_SLOT-1-2*j-k]) begin
          if (j == 0)
            phv_d[C6_BASE + C6_W * int'(entry_p1.idx[N_SLOT-1-2*j-k]) +: C6_W] = val_p1_q.v6[1-k];
          else if (j == 1)
            phv_d[C4_BASE + C4_W * int'(entry_p1.idx[N_SLOT-1-2*j-k]) +: C4_W] = val_p1_q.v4[1-k];
          else
            phv_d[C2_BASE + C2_W * int'(entry_p1.idx[N_SLOT-1-2*j-k]) +: C2_W] = val_p1_q.v2[1-k];
        end
      end
    end
  end

  // ---- stage 1 -> 2: register the modified PHV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phv_out_q <= '0;
      vld_out_q <= 1'b0;
    end else begin
      phv_out_q <= phv_d;
      vld_out_q <= vld_p1_q;
    end
  end

  assign phv_out       = phv_out_q;
  assign phv_valid_out = vld_out_q;

`ifdef KEY_INSERT_STATS_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (vld_p1_q && (|entry_p1.en) && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ins_cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_key_insert.sv
// Directed bench for key_insert with a behavioural container-write model and literal pins.
module tb_key_insert;

  localparam int PHV_LEN = 1124;
  localparam int KEY_LEN = 197;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [PHV_LEN-1:0]  phv_in;
  logic                phv_valid_in;
  logic [KEY_LEN-1:0]  val_in;
  logic [31:0]         ins_off_entry_in;
  logic                ins_off_entry_in_valid;
  logic [3:0]          ins_off_entry_addr;
  logic [PHV_LEN-1:0]  phv_out;
  logic                phv_valid_out;
`ifdef KEY_INSERT_STATS_EN
  logic [31:0]         ins_cnt_out;
`endif

  always #5 clk = ~clk;

  key_insert dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .phv_in                 (phv_in),
    .phv_valid_in           (phv_valid_in),
    .val_in                 (val_in),
    .ins_off_entry_in       (ins_off_entry_in),
    .ins_off_entry_in_valid (ins_off_entry_in_valid),
    .ins_off_entry_addr     (ins_off_entry_addr),
    .phv_out                (phv_out),
    .phv_valid_out          (phv_valid_out)
`ifdef KEY_INSERT_STATS_EN
    ,
    .ins_cnt_out            (ins_cnt_out)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_vout = 0;
  logic [PHV_LEN-1:0] outq [$];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, a, e);
  endtask

  task automatic chk_phv(input string nm, input logic [PHV_LEN-1:0] a, input logic [PHV_LEN-1:0] e);
    int b;
    n_chk++;
    if (a === e) n_pass++;
    else begin
      b = 0;
      for (int i = 0; i < PHV_LEN; i++) if (a[i] !== e[i]) begin b = i; break; end
      $display("FAIL %s: first bad bit %0d, actual bits[b+:32] %h required %h",
               nm, b, 32'(a >> b), 32'(e >> b));
    end
  endtask

  // Reference: every container takes the value of the lowest-numbered enabled slot aimed at it.
  function automatic logic [PHV_LEN-1:0] model(input logic [PHV_LEN-1:0] p,
                                               input logic [KEY_LEN-1:0] v,
                                               input logic [23:0] e);
    logic [PHV_LEN-1:0] r;
    int w [6];
    int gbase [3];
    int pos [6];
    int top;
    w = '{48, 48, 32, 32, 16, 16};
    gbase = '{740, 484, 356};
    top = KEY_LEN;
    for (int s = 0; s < 6; s++) begin top -= w[s]; pos[s] = top; end
    r = p;
    for (int g = 0; g < 3; g++)
      for (int c = 0; c < 8; c++)
        for (int s = 2 * g; s < 2 * g + 2; s++)
          if (e[5-s] && int'(e[23-3*s -: 3]) == c) begin
            for (int b = 0; b < w[s]; b++) r[gbase[g] + w[s] * c + b] = v[pos[s] + b];
            break;
          end
    return r;
  endfunction

  logic [23:0]        shadow [16];
  logic [23:0]        cur_ent;
  logic [PHV_LEN-1:0] cur_exp;
  logic               m_vld1, m_vld2, m_any1;
  logic [PHV_LEN-1:0] m_phv1, m_phv2;
  logic [31:0]        m_cnt;

  always @(posedge clk) if (ins_off_entry_in_valid) shadow[ins_off_entry_addr] <= ins_off_entry_in[23:0];

  always_comb begin
    cur_ent = shadow[phv_in[136:133]];
    cur_exp = model(phv_in, val_in, cur_ent);
  end

  // Two-cycle delay line of expected outputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld1 <= 1'b0; m_vld2 <= 1'b0; m_any1 <= 1'b0;
      m_phv1 <= '0;   m_phv2 <= '0;   m_cnt  <= '0;
    end else begin
      m_vld1 <= phv_valid_in;
      m_phv1 <= cur_exp;
      m_any1 <= phv_valid_in && (cur_ent[5:0] != 6'd0);
      m_vld2 <= m_vld1;
      m_phv2 <= m_phv1;
      if (m_any1 && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_vld", 64'(phv_valid_out), 64'd0);
      chk_phv("rst_phv", phv_out, '0);
    end else begin
      chk("vld", 64'(phv_valid_out), 64'(m_vld2));
      if (m_vld2) chk_phv("phv", phv_out, m_phv2);
      if (phv_valid_out) begin outq.push_back(phv_out); n_vout++; end
    end
`ifdef KEY_INSERT_STATS_EN
    chk("cnt", 64'(ins_cnt_out), 64'(m_cnt));
`endif
  end

  task automatic step(input logic [PHV_LEN-1:0] p, input logic [KEY_LEN-1:0] v, input logic vld,
                      input logic we, input logic [3:0] wa, input logic [23:0] wd);
    @(posedge clk); #1;
    phv_in = p; val_in = v; phv_valid_in = vld;
    ins_off_entry_in_valid = we; ins_off_entry_addr = wa; ins_off_entry_in = {8'h00, wd};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 4'd0, 24'd0);
  endtask

  task automatic take_out(input string nm, output logic [PHV_LEN-1:0] o);
    int n;
    n = 0;
    while (outq.size() == 0 && n < 20) begin @(negedge clk); n++; end
    n_chk++;
    if (outq.size() == 0) begin
      $display("FAIL %s: no valid output within %0d cycles, required one", nm, n);
      o = '0;
    end else begin
      n_pass++;
      o = outq.pop_front();
    end
  endtask

  function automatic logic [PHV_LEN-1:0] rnd_phv(input logic [11:0] vlan);
    logic [PHV_LEN-1:0] r;
    for (int i = 0; i < PHV_LEN; i++) r[i] = 1'($urandom);
    r[140:129] = vlan;
    return r;
  endfunction

  function automatic logic [KEY_LEN-1:0] rnd_val();
    logic [KEY_LEN-1:0] r;
    for (int i = 0; i < KEY_LEN; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  logic [PHV_LEN-1:0] a, b, o, exp_p;
  logic [KEY_LEN-1:0] va, vb;
  logic [PHV_LEN-1:0] saved [10];
  int v0;

  initial begin
    phv_in = '0; val_in = '0; phv_valid_in = 1'b0;
    ins_off_entry_in = '0; ins_off_entry_in_valid = 1'b0; ins_off_entry_addr = '0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) step('0, '0, 1'b0, 1'b1, 4'(i), 24'd0);
    idle(1);
    rst_n = 1'b1;
    idle(2);

    // 1: slot0 -> cont_6B[7]
    step('0, '0, 1'b0, 1'b1, 4'd2, 24'hE00020);
    a = rnd_phv(12'h020); va = rnd_val(); va[196:149] = 48'hAABBCCDDEEFF;
    outq.delete();
    step(a, va, 1'b1, 1'b0, 4'd0, 24'd0);
    idle(1);
    take_out("t1_out", o);
    chk("t1_slot0", 64'(o[1123:1076]), 64'h0000AABBCCDDEEFF);
    chk_phv("t1_rest", {48'd0, o[1075:0]}, {48'd0, a[1075:0]});

    // 2: slots 0 and 1 collide on cont_6B[3]
    step('0, '0, 1'b0, 1'b1, 4'd3, 24'h6C0030);
    b = rnd_phv(12'h030); vb = rnd_val();
    vb[196:149] = 48'h111111111111; vb[148:101] = 48'h222222222222;
    outq.delete();
    step(b, vb, 1'b1, 1'b0, 4'd0, 24'd0);
    idle(1);
    take_out("t2_out", o);
    chk("t2_collide", 64'(o[931:884]), 64'h0000111111111111);

    // 3: disabled entry, 10 back-to-back PHVs pass bit-exact
    outq.delete();
    v0 = n_vout;
    for (int i = 0; i < 10; i++) begin
      saved[i] = rnd_phv(12'h00F);
      step(saved[i], rnd_val(), 1'b1, 1'b0, 4'd0, 24'd0);
    end
    idle(4);
    chk("t3_count", 64'(n_vout - v0), 64'd10);
    for (int i = 0; i < 10; i++) begin
      take_out("t3_out", o);
      chk_phv("t3_passthru", o, saved[i]);
    end

    // 4: same-cycle write is read-first
    a = rnd_phv(12'h050); va = rnd_val(); va[20:5] = 16'hBEEF;
    b = rnd_phv(12'h051); vb = rnd_val(); vb[20:5] = 16'h1234;
    outq.delete();
    step(a, va, 1'b1, 1'b1, 4'd5, 24'h000001);
    step(b, vb, 1'b1, 1'b0, 4'd0, 24'd0);
    idle(1);
    take_out("t4_out_a", o);
    chk_phv("t4_same_cycle", o, a);
    take_out("t4_out_b", o);
    chk("t4_next", 64'(o[371:356]), 64'h1234);
    exp_p = b; exp_p[371:356] = 16'h1234;
    chk_phv("t4_next_rest", o, exp_p);

    // 5: reset with PHVs in flight
    step(rnd_phv(12'h001), rnd_val(), 1'b1, 1'b0, 4'd0, 24'd0);
    step(rnd_phv(12'h002), rnd_val(), 1'b1, 1'b0, 4'd0, 24'd0);
    step(rnd_phv(12'h003), rnd_val(), 1'b1, 1'b0, 4'd0, 24'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 64'(phv_valid_out), 64'd0);
    chk_phv("t5_rst_phv", phv_out, '0);
    step(rnd_phv(12'h004), rnd_val(), 1'b1, 1'b0, 4'd0, 24'd0);
    idle(1);
    outq.delete();
    rst_n = 1'b1;
    idle(3);
    chk("t5_no_out", 64'(outq.size()), 64'd0);
    a = rnd_phv(12'h00A);
    step(a, rnd_val(), 1'b1, 1'b0, 4'd0, 24'd0);
    idle(1);
    @(negedge clk);
    chk("t5_lat1", 64'(phv_valid_out), 64'd0);
    @(negedge clk);
    chk("t5_lat2", 64'(phv_valid_out), 64'd1);
    chk_phv("t5_data", phv_out, a);

    // 6: 3 enabled and 2 disabled PHVs for the insert counter
    for (int i = 0; i < 5; i++)
      step(rnd_phv(i < 3 ? 12'h020 : 12'h000), rnd_val(), 1'b1, 1'b0, 4'd0, 24'd0);
    idle(4);
`ifdef KEY_INSERT_STATS_EN
    chk("t6_cnt", 64'(ins_cnt_out), 64'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
